// File: rtl/prog_seq.sv
// Program sequencer: PC register with IDLE/RUN/HALTED control FSM,
// branch/jump/call/return ops and a bounded LIFO return stack.
module prog_seq #(
   parameter int unsigned     L         = 10,
   parameter int unsigned     D         = 4,
   parameter logic [L-1:0]    RESET_VEC = '0
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic                     Stall,
   input  logic [2:0]               Op,
   input  logic [L-1:0]             Target,
   output logic [L-1:0]             ProgCtr,
   output logic [$clog2(D+1)-1:0]   Depth,
   output logic                     Done,
   output logic                     StkErr
);

   localparam int unsigned DW = $clog2(D + 1);
   localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_NEXT = 3'b000,
      OP_BREL = 3'b001,
      OP_JABS = 3'b010,
      OP_CALL = 3'b011,
      OP_RET  = 3'b100,
      OP_HALT = 3'b101
   } op_e;

   state_e          state_q, state_d;
   logic [L-1:0]    pc_q, pc_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            err_q, err_d;
   logic            done_q;
   logic [L-1:0]    stack_q [D];
   logic            push;
   logic [L-1:0]    ret_addr;

   assign ret_addr = pc_q + L'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!Start) state_d = RUN;
         end
         RUN: begin
            if (!Stall && !Start) begin
               case (op_e'(Op))
                  OP_BREL: pc_d = pc_q + Target;
                  OP_JABS: pc_d = Target;
                  OP_CALL: begin
                     if (depth_q == DW'(D)) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                     end else begin
                        push    = 1'b1;
                        pc_d    = Target;
                        depth_d = depth_q + DW'(1);
                     end
                  end
                  OP_RET: begin
                     if (depth_q == '0) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                     end else begin
                        pc_d    = stack_q[IW'(depth_q - DW'(1))];
                        depth_d = depth_q - DW'(1);
                     end
                  end
                  OP_HALT: state_d = HALTED;
                  default: pc_d = ret_addr;
               endcase
            end
         end
         HALTED: begin
            if (Start) begin
               pc_d    = RESET_VEC;
               depth_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Done tracks the next state so it is high exactly while state_q is HALTED.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
         done_q  <= (state_d == HALTED);
      end
   end

   // Entry storage is not reset; Depth alone defines which entries are valid.
   always_ff @(posedge Clk) begin
      if (!Reset && push) stack_q[IW'(depth_q)] <= ret_addr;
   end

   assign ProgCtr = pc_q;
   assign Depth   = depth_q;
   assign Done    = done_q;
   assign StkErr  = err_q;

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter L, default 10, sets the program counter width and the return-address width in bits; L SHALL be at least 2.
REQ-002 Parameter D, default 4, sets the return-stack depth in entries; D SHALL be at least 1.
REQ-003 Parameter RESET_VEC, default 0, is the L-bit value the PC takes on reset and on restart.
REQ-004 Clk  input  1  clock; all state SHALL change on posedge Clk only.
REQ-005 Reset  input  1  reset; synchronous and active-high.
REQ-006 Start  input  1  hold/restart request; 1 = hold the PC, or restart when halted.
REQ-007 Stall  input  1  pipeline freeze; 1 = no state change while in RUN.
REQ-008 Op  input  3  control op: 000 NEXT, 001 BREL, 010 JABS, 011 CALL, 100 RET, 101 HALT; 110 and 111 SHALL behave as NEXT.
REQ-009 Target  input  L  branch offset (BREL) or absolute address (JABS, CALL).
REQ-010 ProgCtr  output  L  the program counter register.
REQ-011 Depth  output  $clog2(D+1)  number of valid return-stack entries.
REQ-012 Done  output  1  high while the FSM is in HALTED.
REQ-013 StkErr  output  1  sticky flag for return-stack overflow or underflow.

Function
REQ-014 FSM states SHALL be IDLE, RUN and HALTED; state is registered and does not change combinationally.
REQ-015 In IDLE, ProgCtr SHALL hold and Op SHALL be ignored; Start=0 moves the FSM to RUN on the next edge, with no PC change on that edge.
REQ-016 In RUN with Stall=1, ProgCtr, stack contents, Depth, StkErr and state SHALL all hold.
REQ-017 In RUN with Stall=0 and Start=1, the block SHALL hold exactly as with Stall=1.
REQ-018 In RUN with Stall=0 and Start=0, NEXT SHALL update ProgCtr to ProgCtr+1.
REQ-019 In RUN with Stall=0 and Start=0, BREL SHALL update ProgCtr to ProgCtr+Target.
REQ-020 In RUN with Stall=0 and Start=0, JABS SHALL update ProgCtr to Target.
REQ-021 CALL SHALL push ProgCtr+1 and update ProgCtr to Target.
REQ-022 RET SHALL pop the top entry into ProgCtr.
REQ-023 HALT SHALL hold ProgCtr and move the FSM to HALTED.
REQ-024 All PC arithmetic SHALL be modulo 2^L; 2^L-1 plus 1 wraps to 0, and a negative BREL offset is the two's-complement L-bit Target.
REQ-025 The return stack is LIFO with D entries; Depth SHALL increment on a successful CALL and decrement on a successful RET, in the same edge as the PC update.
REQ-026 CALL with Depth==D (overflow) SHALL set StkErr, leave the stack and ProgCtr unchanged, and move the FSM to HALTED.
REQ-027 RET with Depth==0 (underflow) SHALL set StkErr, leave ProgCtr unchanged, and move the FSM to HALTED.
REQ-028 CALL with Depth==D-1 SHALL succeed, and Depth SHALL become D.
REQ-029 In HALTED, ProgCtr, the stack and Depth SHALL hold, and Op and Stall SHALL be ignored.
REQ-030 In HALTED, Start=1 SHALL load ProgCtr=RESET_VEC, clear Depth and StkErr, and move the FSM to IDLE.
REQ-031 Done SHALL be a registered decode of state==HALTED, valid in the same cycle the state register shows HALTED.
REQ-032 The pushed return address for a CALL at 2^L-1 SHALL be 0.

Reset
REQ-033 Reset=1 at posedge Clk SHALL set ProgCtr=RESET_VEC, state=IDLE, Depth=0, StkErr=0 and Done=0, overriding Start, Stall and Op.
REQ-034 Reset asserted mid-operation (in RUN or HALTED, including during a CALL or RET cycle) SHALL discard the pending op and the stack contents.
REQ-035 Stack entry storage need not be cleared on reset; only Depth is cleared.

Verification
REQ-036 Reset, then Start=0 and Op=NEXT for 5 cycles (L=10, RESET_VEC=0) -> ProgCtr 0,0,1,2,3,4 (IDLE-to-RUN edge shows no increment).
REQ-037 ProgCtr=1023 with Op=NEXT -> ProgCtr=0; then ProgCtr=5 with BREL and Target=10'h3FE -> ProgCtr=3.
REQ-038 At ProgCtr=20: CALL Target=100, then at 100 CALL Target=200, then RET, then RET -> ProgCtr 100,200,101,21 and Depth 1,2,1,0.
REQ-039 D=4: issue five CALLs -> after the fifth, StkErr=1, Done=1, Depth=4, and ProgCtr equals the fourth Target; then Start=1 -> ProgCtr=RESET_VEC, StkErr=0, state=IDLE.
REQ-040 RET at Depth=0 -> StkErr=1 and Done=1; Stall=1 during a JABS in RUN -> ProgCtr unchanged.
REQ-041 Reset asserted in the same cycle as a CALL at Depth=2 -> ProgCtr=RESET_VEC, Depth=0, state=IDLE.
